// File: rtl/rgb2gray_cfg.sv
// rgb2gray_cfg: configurable RGB-to-luma converter on a valid/ready stream.
// Luma = sat((R*cr + G*cg + B*cb + 128) >> 8) with Q1.8 coefficients chosen
// from a preset or a custom set. Config is staged in a shadow copy and only
// becomes active on an accepted start-of-frame beat.
module rgb2gray_cfg #(
    parameter int WIDTH_P  = 8,
    parameter int USER_W_P = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // input stream
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [WIDTH_P-1:0]  red_i,
    input  logic [WIDTH_P-1:0]  green_i,
    input  logic [WIDTH_P-1:0]  blue_i,
    input  logic [USER_W_P-1:0] user_i,
    // output stream
    output logic                valid_o,
    input  logic                ready_i,
    output logic [WIDTH_P-1:0]  gray_o,
    output logic [USER_W_P-1:0] user_o,
    // configuration
    input  logic                cfg_we_i,
    input  logic [1:0]          cfg_mode_i,
    input  logic [8:0]          cfg_cr_i,
    input  logic [8:0]          cfg_cg_i,
    input  logic [8:0]          cfg_cb_i,
    output logic                cfg_pending_o
);

    localparam int COEF_W = 9;
    localparam int PROD_W = WIDTH_P + COEF_W;
    localparam int SUM_W  = WIDTH_P + 11;

    typedef enum logic [1:0] {
        MODE_BT601  = 2'd0,
        MODE_BT709  = 2'd1,
        MODE_AVG    = 2'd2,
        MODE_CUSTOM = 2'd3
    } mode_e;

    // ------------------------------------------------------------------
    // Configuration state
    // ------------------------------------------------------------------
    mode_e               shadow_mode_q;
    logic [COEF_W-1:0]   shadow_cr_q;
    logic [COEF_W-1:0]   shadow_cg_q;
    logic [COEF_W-1:0]   shadow_cb_q;
    mode_e               active_mode_q;
    logic [COEF_W-1:0]   active_cr_q;
    logic [COEF_W-1:0]   active_cg_q;
    logic [COEF_W-1:0]   active_cb_q;
    logic                pending_q;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic                s1_valid_q;
    logic [PROD_W-1:0]   s1_prod_r_q;
    logic [PROD_W-1:0]   s1_prod_g_q;
    logic [PROD_W-1:0]   s1_prod_b_q;
    logic [USER_W_P-1:0] s1_user_q;

    logic                s2_valid_q;
    logic [SUM_W-1:0]    s2_sum_q;
    logic [USER_W_P-1:0] s2_user_q;

    logic                s3_valid_q;
    logic [WIDTH_P-1:0]  s3_gray_q;
    logic [USER_W_P-1:0] s3_user_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                s1_ld;
    logic                s2_ld;
    logic                s3_ld;
    logic                in_fire;
    logic                commit;

    mode_e               eff_mode;
    logic [COEF_W-1:0]   eff_cr;
    logic [COEF_W-1:0]   eff_cg;
    logic [COEF_W-1:0]   eff_cb;
    logic [COEF_W-1:0]   coef_r;
    logic [COEF_W-1:0]   coef_g;
    logic [COEF_W-1:0]   coef_b;

    logic [PROD_W-1:0]   prod_r_d;
    logic [PROD_W-1:0]   prod_g_d;
    logic [PROD_W-1:0]   prod_b_d;
    logic [SUM_W-1:0]    sum_d;
    logic [SUM_W-1:0]    rnd_d;
    logic [SUM_W-1:0]    shr_d;
    logic [WIDTH_P-1:0]  gray_d;

    // Elastic handshake: a stage loads when it is empty or its content moves on.
    always_comb begin
        s3_ld   = !s3_valid_q || ready_i;
        s2_ld   = !s2_valid_q || s3_ld;
        s1_ld   = !s1_valid_q || s2_ld;
        in_fire = valid_i && s1_ld;
        commit  = in_fire && user_i[0] && pending_q;
    end

    assign ready_o       = s1_ld;
    assign valid_o       = s3_valid_q;
    assign gray_o        = s3_gray_q;
    assign user_o        = s3_user_q;
    assign cfg_pending_o = pending_q;

    // Shadow/active config registers; commit copies the pre-write shadow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_mode_q <= MODE_BT601;
            shadow_cr_q   <= 9'd77;
            shadow_cg_q   <= 9'd150;
            shadow_cb_q   <= 9'd29;
            active_mode_q <= MODE_BT601;
            active_cr_q   <= 9'd77;
            active_cg_q   <= 9'd150;
            active_cb_q   <= 9'd29;
            pending_q     <= 1'b0;
        end else begin
            if (commit) begin
                active_mode_q <= shadow_mode_q;
                active_cr_q   <= shadow_cr_q;
                active_cg_q   <= shadow_cg_q;
                active_cb_q   <= shadow_cb_q;
            end
            if (cfg_we_i) begin
                shadow_mode_q <= mode_e'(cfg_mode_i);
                shadow_cr_q   <= cfg_cr_i;
                shadow_cg_q   <= cfg_cg_i;
                shadow_cb_q   <= cfg_cb_i;
                pending_q     <= 1'b1;
            end else if (commit) begin
                pending_q     <= 1'b0;
            end
        end
    end

    // Coefficient selection; the committing sof beat already sees the shadow set.
    always_comb begin
        eff_mode = commit ? shadow_mode_q : active_mode_q;
        eff_cr   = commit ? shadow_cr_q   : active_cr_q;
        eff_cg   = commit ? shadow_cg_q   : active_cg_q;
        eff_cb   = commit ? shadow_cb_q   : active_cb_q;
        coef_r   = 9'd77;
        coef_g   = 9'd150;
        coef_b   = 9'd29;
        case (eff_mode)
            MODE_BT601: begin
                coef_r = 9'd77;
                coef_g = 9'd150;
                coef_b = 9'd29;
            end
            MODE_BT709: begin
                coef_r = 9'd54;
                coef_g = 9'd183;
                coef_b = 9'd19;
            end
            MODE_AVG: begin
                coef_r = 9'd85;
                coef_g = 9'd85;
                coef_b = 9'd86;
            end
            MODE_CUSTOM: begin
                coef_r = eff_cr;
                coef_g = eff_cg;
                coef_b = eff_cb;
            end
            default: begin
                coef_r = 9'd77;
                coef_g = 9'd150;
                coef_b = 9'd29;
            end
        endcase
    end

    // Datapath arithmetic for all three stages.
    always_comb begin
        prod_r_d = PROD_W'(red_i)   * PROD_W'(coef_r);
        prod_g_d = PROD_W'(green_i) * PROD_W'(coef_g);
        prod_b_d = PROD_W'(blue_i)  * PROD_W'(coef_b);
        sum_d    = SUM_W'(s1_prod_r_q) + SUM_W'(s1_prod_g_q) + SUM_W'(s1_prod_b_q);
        rnd_d    = s2_sum_q + SUM_W'(128);
        shr_d    = rnd_d >> 8;
        gray_d   = (|shr_d[SUM_W-1:WIDTH_P]) ? '1 : shr_d[WIDTH_P-1:0];
    end

    // S1: register the three weighted products at input accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_prod_r_q <= '0;
            s1_prod_g_q <= '0;
            s1_prod_b_q <= '0;
            s1_user_q   <= '0;
        end else if (s1_ld) begin
            s1_valid_q <= valid_i;
            if (valid_i) begin
                s1_prod_r_q <= prod_r_d;
                s1_prod_g_q <= prod_g_d;
                s1_prod_b_q <= prod_b_d;
                s1_user_q   <= user_i;
            end
        end
    end

    // S2: register the sum of products.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_user_q  <= '0;
        end else if (s2_ld) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_q  <= sum_d;
                s2_user_q <= s1_user_q;
            end
        end
    end

    // S3: register the rounded, saturated gray value; holds while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s3_valid_q <= 1'b0;
            s3_gray_q  <= '0;
            s3_user_q  <= '0;
        end else if (s3_ld) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_gray_q <= gray_d;
                s3_user_q <= s2_user_q;
            end
        end
    end

endmodule

// File: tb/tb_rgb2gray_cfg.sv
// Scoreboard bench for rgb2gray_cfg: directed beats push hand-computed
// expectations; a negedge monitor pops and compares on each output transfer.
module tb_rgb2gray_cfg;

    localparam int W  = 8;
    localparam int UW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  red_i;
    logic [W-1:0]  green_i;
    logic [W-1:0]  blue_i;
    logic [UW-1:0] user_i;
    logic          valid_o;
    logic          ready_i;
    logic [W-1:0]  gray_o;
    logic [UW-1:0] user_o;
    logic          cfg_we_i;
    logic [1:0]    cfg_mode_i;
    logic [8:0]    cfg_cr_i;
    logic [8:0]    cfg_cg_i;
    logic [8:0]    cfg_cb_i;
    logic          cfg_pending_o;

    rgb2gray_cfg #(
        .WIDTH_P  (W),
        .USER_W_P (UW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .red_i         (red_i),
        .green_i       (green_i),
        .blue_i        (blue_i),
        .user_i        (user_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .gray_o        (gray_o),
        .user_o        (user_o),
        .cfg_we_i      (cfg_we_i),
        .cfg_mode_i    (cfg_mode_i),
        .cfg_cr_i      (cfg_cr_i),
        .cfg_cg_i      (cfg_cg_i),
        .cfg_cb_i      (cfg_cb_i),
        .cfg_pending_o (cfg_pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  gray;
        logic [UW-1:0] user;
        int unsigned   acc;
        bit            lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each output transfer against the scoreboard head and
    // check that a stalled output holds steady.
    exp_t          mon_e;
    bit            hold_v = 1'b0;
    logic [W-1:0]  hold_gray;
    logic [UW-1:0] hold_user;

    always @(negedge clk) begin
        if (rst_i !== 1'b1) begin
            if (hold_v) begin
                chk("stall_valid_held", {31'd0, valid_o}, 32'd1);
                chk("stall_gray_stable", {24'd0, gray_o}, {24'd0, hold_gray});
                chk("stall_user_stable", {30'd0, user_o}, {30'd0, hold_user});
            end
            hold_v    = (valid_o === 1'b1) && (ready_i === 1'b0);
            hold_gray = gray_o;
            hold_user = user_o;
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got gray %0d with no beat expected", gray_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("gray", {24'd0, gray_o}, {24'd0, mon_e.gray});
                    chk("user", {30'd0, user_o}, {30'd0, mon_e.user});
                    if (mon_e.lat) chk("latency", cyc - mon_e.acc, 32'd3);
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    // Drive one beat (called just after a rising edge); returns just after its accept edge.
    task automatic send(input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b,
                        input logic [UW-1:0] u, input logic [W-1:0] eg,
                        input bit lat, input bit push);
        int unsigned waitc = 0;
        exp_t t;
        red_i   = r;
        green_i = g;
        blue_i  = b;
        user_i  = u;
        valid_i = 1'b1;
        @(negedge clk);
        while (ready_o !== 1'b1 && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        if (ready_o !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: ready_o is %b, required 1", ready_o);
        end else if (push) begin
            t.gray = eg;
            t.user = u;
            t.acc  = cyc;
            t.lat  = lat;
            sb.push_back(t);
        end
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        cfg_we_i = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] m, input logic [8:0] cr, input logic [8:0] cg,
                             input logic [8:0] cb);
        cfg_we_i   = 1'b1;
        cfg_mode_i = m;
        cfg_cr_i   = cr;
        cfg_cg_i   = cg;
        cfg_cb_i   = cb;
        @(posedge clk);
        #1;
        cfg_we_i = 1'b0;
    endtask

    task automatic drain();
        int unsigned waitc = 0;
        while (sb.size() != 0 && waitc < 50) begin
            waitc++;
            @(posedge clk);
        end
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_i      = 1'b1;
        valid_i    = 1'b0;
        red_i      = '0;
        green_i    = '0;
        blue_i     = '0;
        user_i     = '0;
        ready_i    = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_mode_i = '0;
        cfg_cr_i   = '0;
        cfg_cg_i   = '0;
        cfg_cb_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_gray_o", {24'd0, gray_o}, 32'd0);
        chk("rst_user_o", {30'd0, user_o}, 32'd0);
        chk("rst_pending", {31'd0, cfg_pending_o}, 32'd0);
        chk("rst_ready_o", {31'd0, ready_o}, 32'd1);

        // Mode 0, back-to-back beats with latency check.
        send(8'd255, 8'd255, 8'd255, 2'd0, 8'd255, 1'b1, 1'b1);
        send(8'd255, 8'd0,   8'd0,   2'd0, 8'd77,  1'b1, 1'b1);
        send(8'd0,   8'd0,   8'd0,   2'd0, 8'd0,   1'b1, 1'b1);

        // Mode 1 committed on sof.
        cfg_write(2'd1, 9'd0, 9'd0, 9'd0);
        chk("pending_after_write_m1", {31'd0, cfg_pending_o}, 32'd1);
        send(8'd0, 8'd200, 8'd0, 2'd1, 8'd143, 1'b1, 1'b1);
        chk("pending_after_commit_m1", {31'd0, cfg_pending_o}, 32'd0);
        send(8'd0, 8'd200, 8'd0, 2'd0, 8'd143, 1'b1, 1'b1);

        // Custom 256/256/256: saturation and unity gain.
        cfg_write(2'd3, 9'd256, 9'd256, 9'd256);
        chk("pending_after_write_m3", {31'd0, cfg_pending_o}, 32'd1);
        send(8'd100, 8'd100, 8'd100, 2'd1, 8'd255, 1'b1, 1'b1);
        chk("pending_after_commit_m3", {31'd0, cfg_pending_o}, 32'd0);
        send(8'd50, 8'd0, 8'd0, 2'd0, 8'd50, 1'b1, 1'b1);

        // Back to mode 0, then a mid-frame write of mode 2 that must wait for sof.
        cfg_write(2'd0, 9'd0, 9'd0, 9'd0);
        send(8'd0, 8'd0, 8'd0, 2'd1, 8'd0, 1'b1, 1'b1);
        cfg_write(2'd2, 9'd77, 9'd150, 9'd29);
        chk("pending_mid_frame", {31'd0, cfg_pending_o}, 32'd1);
        send(8'd90,  8'd90, 8'd90, 2'd0, 8'd90, 1'b1, 1'b1);
        send(8'd255, 8'd0,  8'd0,  2'd2, 8'd77, 1'b1, 1'b1);
        chk("pending_still_set", {31'd0, cfg_pending_o}, 32'd1);
        send(8'd90,  8'd90, 8'd90, 2'd1, 8'd90, 1'b1, 1'b1);
        chk("pending_after_commit_m2", {31'd0, cfg_pending_o}, 32'd0);
        send(8'd255, 8'd0,  8'd0,  2'd0, 8'd85, 1'b1, 1'b1);

        // Backpressure: 6 beats, ready_i low for 8 cycles (mode 2, equal channels -> v).
        drain();
        ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(8'(10 * (i + 1)), 8'(10 * (i + 1)), 8'(10 * (i + 1)),
                         2'(i % 4), 8'(10 * (i + 1)), 1'b0, 1'b1);
                    if (i == 1) chk("ready_after_2_accepts", {31'd0, ready_o}, 32'd1);
                    if (i == 2) chk("ready_after_3_accepts", {31'd0, ready_o}, 32'd0);
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // Write coinciding with the committing sof: old shadow commits, new stays pending.
        cfg_write(2'd1, 9'd0, 9'd0, 9'd0);
        chk("pending_before_overlap", {31'd0, cfg_pending_o}, 32'd1);
        cfg_we_i   = 1'b1;
        cfg_mode_i = 2'd3;
        cfg_cr_i   = 9'd128;
        cfg_cg_i   = 9'd0;
        cfg_cb_i   = 9'd0;
        send(8'd0, 8'd200, 8'd0, 2'd1, 8'd143, 1'b1, 1'b1);
        chk("pending_after_overlap", {31'd0, cfg_pending_o}, 32'd1);
        send(8'd0,   8'd200, 8'd0, 2'd0, 8'd143, 1'b1, 1'b1);
        send(8'd200, 8'd0,   8'd0, 2'd1, 8'd100, 1'b1, 1'b1);
        chk("pending_after_second_commit", {31'd0, cfg_pending_o}, 32'd0);
        drain();

        // Reset with beats in flight and a pending config.
        cfg_write(2'd1, 9'd0, 9'd0, 9'd0);
        send(8'd255, 8'd255, 8'd255, 2'd0, 8'd0, 1'b0, 1'b0);
        send(8'd255, 8'd255, 8'd255, 2'd0, 8'd0, 1'b0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("midrst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("midrst_pending", {31'd0, cfg_pending_o}, 32'd0);
        chk("midrst_ready_o", {31'd0, ready_o}, 32'd1);
        send(8'd255, 8'd0, 8'd0, 2'd1, 8'd77, 1'b1, 1'b1);
        drain();
        repeat (4) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rgb2gray_cfg.md
Name: rgb2gray_cfg

Overview:
Parametrised, configurable successor to the fixed-shift RGB-to-gray converter. It computes luma as a rounded, saturated weighted sum of R, G and B using 9-bit Q1.8 coefficients. The coefficients come from a selectable preset (BT.601, BT.709, average) or from a custom set written through a config port. Config commits only at frame start. The block sits in the video front end between pixel source and line buffer / Sobel stage, on a valid/ready stream with pass-through sideband.

Parameters:
WIDTH_P, 8, bits per colour channel and per gray output
USER_W_P, 2, sideband bits carried alongside each pixel (bit0 = sof, bit1 = eol by convention)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
valid_i  in  1  input beat valid
ready_o  out  1  block can accept input beat
red_i  in  WIDTH_P  red channel
green_i  in  WIDTH_P  green channel
blue_i  in  WIDTH_P  blue channel
user_i  in  USER_W_P  sideband; user_i[0] = start of frame
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts output beat
gray_o  out  WIDTH_P  gray result
user_o  out  USER_W_P  sideband aligned with gray_o
cfg_we_i  in  1  write shadow config this cycle
cfg_mode_i  in  2  0=BT.601, 1=BT.709, 2=average, 3=custom
cfg_cr_i, cfg_cg_i, cfg_cb_i  in  9 each  custom coefficients, Q1.8 (256 = 1.0)
cfg_pending_o  out  1  shadow written but not yet committed

Behaviour:
- Reset is synchronous on rst_i=1 at a clock edge. Outputs go to valid_o=0, gray_o=0, user_o=0, cfg_pending_o=0 and ready_o=1 (after reset). All in-flight beats are discarded.
- Reset also loads the active and shadow config to mode 0 and sets custom coefficients to 77/150/29. Reset mid-stream drops data silently, with no partial output.
- Preset coefficients (R,G,B):
  - mode 0: 77,150,29
  - mode 1: 54,183,19
  - mode 2: 85,85,86
  - mode 3: active custom set
- Handshake:
  - Input beat transfers when valid_i&&ready_o; output beat transfers when valid_o&&ready_i.
  - valid_o must stay asserted and gray_o/user_o stable until accepted.
  - valid_o must not depend combinationally on ready_i.
- Pipeline: 3 elastic register stages, full throughput (1 beat/cycle).
  - S1 registers the three products: channel x coef, each WIDTH_P+9 bits.
  - S2 registers the sum, WIDTH_P+11 bits.
  - S3 adds 128, shifts right by 8, and saturates to 2^WIDTH_P-1 when any bit above WIDTH_P-1 is set.
- Latency is exactly 3 cycles from input accept to valid_o when ready_i is held high.
- Each stage advances when it is empty or the next stage advances. ready_o = !S1_valid || S1_advances. No bubbles are inserted when ready_i is high.
- With ready_i low, the pipeline fills and holds 3 beats; ready_o drops in the cycle after the third beat is accepted. No beat is lost or duplicated.
- user bits travel with their pixel through all stages unchanged.
- Config write:
  - cfg_we_i=1 latches mode and custom coefficients into shadow and sets cfg_pending_o=1.
  - A second write before commit overwrites the shadow.
- Config commit:
  - On accept of an input beat with user_i[0]=1, shadow copies to active when pending. cfg_pending_o clears the next cycle.
  - That sof beat and all later beats use the new coefficients. Earlier beats keep the coefficients they were issued with, because coefficients are applied in S1 at accept.
- Simultaneous cfg_we_i and sof accept: the sof beat commits the old shadow contents. The new write lands in shadow, and cfg_pending_o remains 1.
- No commit ever occurs without a sof beat.
- Arithmetic is unsigned throughout; coefficient sums above 256 are legal and saturate.

Test Plan:
- Reset, mode 0, inputs (255,255,255), then (255,0,0), then (0,0,0) back-to-back with ready_i=1 -> gray_o 255, 77, 0 on cycles 3, 4, 5 after first accept; valid_o high 3 consecutive cycles.
- Write mode 1, then send sof beat (0,200,0) -> cfg_pending_o 1 then 0 after commit; gray_o=143. A following beat (0,200,0) also gives 143.
- Write mode 3 with coefs 256,256,256, then sof beat (100,100,100) -> gray_o=255 (saturated from 300); beat (50,0,0) -> 50.
- Mid-frame config write to mode 2 with non-sof beats (90,90,90) -> results stay mode-0 (90) and cfg_pending_o stays 1. The next sof beat (90,90,90) -> 90 via mode 2, and pending clears.
- Backpressure: 6 beats with user values 0..3 cycling, ready_i low for 8 cycles then high -> ready_o low after 3 accepts. All 6 outputs then emerge in order with correct gray/user values; gray_o stays stable while stalled.
- Assert rst_i for one cycle with 2 beats in flight and pending config -> valid_o=0 and cfg_pending_o=0 next cycle. After reset, beat (255,0,0) yields 77, confirming mode 0 is restored.
